user_clock_lock_sequencer: RTL
==============================

Name: user_clock_lock_sequencer

Overview:
- Companion to the user-clock MMCM wrapper. Drives the MMCM reset and consumes its raw LOCKED output.
- Synchronizes and qualifies LOCKED, retries the MMCM on lock timeout, and produces a clean, stretched active-low reset plus status for user logic.
- Runs on a free-running reference clock, never on the MMCM output, so that it keeps operating through lock loss.

Parameters:
- SYNC_STAGES, 2, flops in the LOCKED synchronizer chain (min 2).
- MMCM_RST_CYCLES, 8, cycles MMCM_RST is held high per entry to S_MMCM_RST (min 1).
- LOCK_TIMEOUT, 65536, max cycles allowed in S_WAIT_LOCK plus S_STABLE before retrying the MMCM.
- STABLE_CYCLES, 256, consecutive synced-lock-high cycles required (min 1).
- RST_HOLD_CYCLES, 16, cycles RST_N_OUT stays low after lock qualifies (min 1).
- CNT_W, 8, width of the saturating status counters.

Ports:
- CLK  in  1  free-running reference clock.
- RST  in  1  reset, synchronous to CLK, active-high.
- LOCKED_IN  in  1  raw MMCM LOCKED, asynchronous to CLK.
- MMCM_RST  out  1  active-high reset to the MMCM.
- RST_N_OUT  out  1  active-low user reset, registered, synchronous to CLK.
- READY  out  1  high exactly when the FSM is in S_RUN.
- STATE  out  3  current FSM state encoding.
- RETRY_CNT  out  CNT_W  timeout-triggered MMCM retries, saturating.
- LOSS_CNT  out  CNT_W  lock losses after qualification, saturating.

Behaviour:
- RST high at a CLK edge: all outputs and registers take reset values at that edge. Applies mid-operation too.
  - State = S_MMCM_RST, MMCM_RST=1, RST_N_OUT=0, READY=0, all counters 0, synchronizer cleared to 0.
- lock_s is LOCKED_IN delayed by SYNC_STAGES flops. The FSM only ever uses lock_s.
- All outputs are registered and reflect the state entered at the same edge.
- States and encoding: S_MMCM_RST=0, S_WAIT_LOCK=1, S_STABLE=2, S_HOLD=3, S_RUN=4.
- S_MMCM_RST:
  - MMCM_RST=1 for exactly MMCM_RST_CYCLES cycles, then go to S_WAIT_LOCK.
  - lock_s is ignored. Entering this state clears the timeout counter.
- S_WAIT_LOCK:
  - The timeout counter increments every cycle in S_WAIT_LOCK or S_STABLE.
  - lock_s=1: go to S_STABLE with the stable counter reset.
- S_STABLE:
  - lock_s=0: return to S_WAIT_LOCK. The timeout counter is NOT reset, so a bouncing lock still times out.
  - Once lock_s has been 1 for STABLE_CYCLES consecutive cycles, go to S_HOLD.
- Timeout: when the timeout counter reaches LOCK_TIMEOUT in S_WAIT_LOCK or S_STABLE, go to S_MMCM_RST and increment RETRY_CNT.
  - If STABLE completion and timeout occur in the same cycle, completion wins.
- S_HOLD:
  - RST_N_OUT=0 for RST_HOLD_CYCLES cycles, then go to S_RUN.
  - lock_s=0 here counts as a loss: increment LOSS_CNT and go to S_MMCM_RST.
- S_RUN:
  - RST_N_OUT=1, READY=1.
  - lock_s=0: at the next edge RST_N_OUT=0, READY=0, LOSS_CNT increments, state goes to S_MMCM_RST.
- Latency: the first edge sampling LOCKED_IN=1 is edge E, with LOCKED_IN held high afterwards. RST_N_OUT rises at E + SYNC_STAGES + STABLE_CYCLES + RST_HOLD_CYCLES.
- Counters saturate at all-ones and never wrap. Only RST clears them.
- MMCM_RST and RST_N_OUT are never both high.
- Internal counter widths are clog2 of the respective parameter plus 1. No overflow is permitted.

Decomposition:
- Shared package user_clock_pkg holds:
  - the state typedef and encodings above;
  - a clog2 helper function;
  - default parameter constants.
- Sub-module user_clock_sync_bit: an SYNC_STAGES-deep 1-bit synchronizer with synchronous active-high clear. It is reused by other clock-crossing blocks.

Test Plan:
- Bench parameters for all scenarios: SYNC_STAGES=2, MMCM_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, RST_HOLD_CYCLES=4, CNT_W=4.
- Nominal bring-up: release RST, raise LOCKED_IN 10 cycles later and hold it.
  - MMCM_RST is high for exactly 4 cycles after release.
  - RST_N_OUT and READY rise exactly 14 edges after the first edge sampling LOCKED_IN=1.
- Timeout: LOCKED_IN held 0.
  - MMCM_RST re-pulses for 4 cycles every 36 cycles.
  - RETRY_CNT counts 1, 2, 3, … and saturates at 15 without wrapping.
- Bouncing lock: LOCKED_IN toggles high 5 cycles / low 2 cycles.
  - S_HOLD is never reached.
  - Timeout fires 32 cycles after entering S_WAIT_LOCK. RETRY_CNT=1.
- Loss in run: after READY=1, drop LOCKED_IN for 1 cycle.
  - RST_N_OUT falls exactly 3 edges later. LOSS_CNT=1. STATE=0.
  - Raising LOCKED_IN again gives a full re-sequence to READY.
- Loss in hold and reset mid-operation:
  - Drop LOCKED_IN to give lock_s=0 during S_HOLD: expect S_MMCM_RST and LOSS_CNT=1.
  - Assert RST for 1 cycle while in S_STABLE: all outputs show reset values at the next edge and counters clear.

Source files
------------

// File: rtl/user_clock_pkg.sv
// Shared definitions for the user-clock lock sequencer: state encodings,
// default parameter values and a width helper.
package user_clock_pkg;

    // 3-bit state code, also exported on the STATE status port
    typedef logic [2:0] state_t;

    localparam state_t S_MMCM_RST  = 3'd0;
    localparam state_t S_WAIT_LOCK = 3'd1;
    localparam state_t S_STABLE    = 3'd2;
    localparam state_t S_HOLD      = 3'd3;
    localparam state_t S_RUN       = 3'd4;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_MMCM_RST_CYCLES = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT    = 65536;
    localparam int unsigned DEF_STABLE_CYCLES   = 256;
    localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
    localparam int unsigned DEF_CNT_W           = 8;

    // Ceiling log2; returns 0 for inputs of 0 or 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/user_clock_lock_sequencer_if.sv
// MMCM-side and user-side signal bundle of the lock sequencer.
// master: the sequencer; slave: the MMCM wrapper / user logic side.
interface user_clock_lock_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             LOCKED_IN;
    logic             MMCM_RST;
    logic             RST_N_OUT;
    logic             READY;
    logic [2:0]       STATE;
    logic [CNT_W-1:0] RETRY_CNT;
    logic [CNT_W-1:0] LOSS_CNT;

    modport master (
        input  LOCKED_IN,
        output MMCM_RST,
        output RST_N_OUT,
        output READY,
        output STATE,
        output RETRY_CNT,
        output LOSS_CNT
    );

    modport slave (
        output LOCKED_IN,
        input  MMCM_RST,
        input  RST_N_OUT,
        input  READY,
        input  STATE,
        input  RETRY_CNT,
        input  LOSS_CNT
    );

endinterface

// File: rtl/user_clock_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high clear.
// Shared by the clock-crossing blocks of the user-clock subsystem.
module user_clock_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; clear empties it
    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/user_clock_lock_sequencer.sv
// User-clock lock sequencer: pulses the MMCM reset, qualifies the
// synchronized LOCKED signal, retries on timeout and produces a stretched
// active-low user reset plus status. Runs on the free-running reference clock.
module user_clock_lock_sequencer
    import user_clock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                        CLK,
    input  logic                        RST,
    user_clock_lock_sequencer_if.master bus
);

    localparam int unsigned MR_W = clog2(MMCM_RST_CYCLES) + 1;
    localparam int unsigned TO_W = clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned ST_W = clog2(STABLE_CYCLES) + 1;
    localparam int unsigned HD_W = clog2(RST_HOLD_CYCLES) + 1;

    // Counter values on the last cycle of each timed interval
    localparam logic [MR_W-1:0] MR_LAST = MR_W'(MMCM_RST_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(RST_HOLD_CYCLES - 1);

    logic             lock_s;

    state_t           state;
    state_t           state_nx;
    logic [MR_W-1:0]  mr_cnt;
    logic [MR_W-1:0]  mr_cnt_nx;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nx;
    logic [ST_W-1:0]  st_cnt;
    logic [ST_W-1:0]  st_cnt_nx;
    logic [HD_W-1:0]  hd_cnt;
    logic [HD_W-1:0]  hd_cnt_nx;
    logic             retry_inc;
    logic             loss_inc;

    logic             mmcm_rst_q;
    logic             rst_n_q;
    logic             ready_q;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    user_clock_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (CLK),
        .clr (RST),
        .d   (bus.LOCKED_IN),
        .q   (lock_s)
    );

    // Next-state and interval-counter logic; every exit into S_MMCM_RST
    // restarts both the reset-pulse and the timeout counters
    always_comb begin
        state_nx  = state;
        mr_cnt_nx = mr_cnt;
        to_cnt_nx = to_cnt;
        st_cnt_nx = st_cnt;
        hd_cnt_nx = hd_cnt;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;

        case (state)
            S_MMCM_RST: begin
                to_cnt_nx = '0;
                if (mr_cnt == MR_LAST) begin
                    state_nx  = S_WAIT_LOCK;
                    mr_cnt_nx = '0;
                end else begin
                    mr_cnt_nx = mr_cnt + MR_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                to_cnt_nx = to_cnt + TO_W'(1);
                if (to_cnt == TO_LAST) begin
                    state_nx  = S_MMCM_RST;
                    mr_cnt_nx = '0;
                    to_cnt_nx = '0;
                    retry_inc = 1'b1;
                end else if (lock_s) begin
                    state_nx  = S_STABLE;
                    st_cnt_nx = '0;
                end
            end

            S_STABLE: begin
                to_cnt_nx = to_cnt + TO_W'(1);
                // Completion outranks a coincident timeout; a timeout
                // outranks falling back to S_WAIT_LOCK
                if (lock_s && (st_cnt == ST_LAST)) begin
                    state_nx  = S_HOLD;
                    hd_cnt_nx = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_nx  = S_MMCM_RST;
                    mr_cnt_nx = '0;
                    to_cnt_nx = '0;
                    retry_inc = 1'b1;
                end else if (!lock_s) begin
                    state_nx = S_WAIT_LOCK;
                end else begin
                    st_cnt_nx = st_cnt + ST_W'(1);
                end
            end

            S_HOLD: begin
                if (!lock_s) begin
                    state_nx  = S_MMCM_RST;
                    mr_cnt_nx = '0;
                    to_cnt_nx = '0;
                    loss_inc  = 1'b1;
                end else if (hd_cnt == HD_LAST) begin
                    state_nx = S_RUN;
                end else begin
                    hd_cnt_nx = hd_cnt + HD_W'(1);
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_nx  = S_MMCM_RST;
                    mr_cnt_nx = '0;
                    to_cnt_nx = '0;
                    loss_inc  = 1'b1;
                end
            end

            default: begin
                state_nx  = S_MMCM_RST;
                mr_cnt_nx = '0;
                to_cnt_nx = '0;
            end
        endcase
    end

    // State, interval counters and outputs decoded from the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_MMCM_RST;
            mr_cnt     <= '0;
            to_cnt     <= '0;
            st_cnt     <= '0;
            hd_cnt     <= '0;
            mmcm_rst_q <= 1'b1;
            rst_n_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            mr_cnt     <= mr_cnt_nx;
            to_cnt     <= to_cnt_nx;
            st_cnt     <= st_cnt_nx;
            hd_cnt     <= hd_cnt_nx;
            mmcm_rst_q <= (state_nx == S_MMCM_RST);
            rst_n_q    <= (state_nx == S_RUN);
            ready_q    <= (state_nx == S_RUN);
        end
    end

    // Saturating retry / loss status counters, cleared only by RST
    always_ff @(posedge CLK) begin
        if (RST) begin
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            if (retry_inc && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (loss_inc && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.MMCM_RST  = mmcm_rst_q;
    assign bus.RST_N_OUT = rst_n_q;
    assign bus.READY     = ready_q;
    assign bus.STATE     = state;
    assign bus.RETRY_CNT = retry_cnt;
    assign bus.LOSS_CNT  = loss_cnt;

endmodule
